// File: rtl/jtag_gpio_ctrl.sv
// JTAG-controlled GPIO controller.
// A single scan register serves four DR views: data, config, edge status and set/clear.
// Inputs pass through a synchroniser, and then through a per-pin edge detector.
// Edge status bits are sticky and are cleared by writing 1.
module jtag_gpio_ctrl #(
    parameter int NR_GPIOS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                tck,
    input  logic                reset_,
    input  logic                tdi,
    output logic                gpios_tdo,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic                gpio_data_ir,
    input  logic                gpio_config_ir,
    input  logic                gpio_edge_ir,
    input  logic                gpio_setclr_ir,
    input  logic [NR_GPIOS-1:0] gpio_inputs,
    output logic [NR_GPIOS-1:0] gpio_outputs,
    output logic [NR_GPIOS-1:0] gpio_outputs_ena,
    output logic                edge_pending
);

    localparam int SR_W = 3 * NR_GPIOS;

    logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
    logic [NR_GPIOS-1:0] in_sync;
    logic [NR_GPIOS-1:0] in_prev;
    logic [NR_GPIOS-1:0] rise_ena;
    logic [NR_GPIOS-1:0] fall_ena;
    logic [NR_GPIOS-1:0] edge_status;
    logic [NR_GPIOS-1:0] new_edges;
    logic [SR_W-1:0]     sr;
    logic [SR_W-1:0]     sr_down;
    logic [SR_W-1:0]     sr_shifted;
    logic [SR_W-1:0]     sr_capture;

    logic sel_data;
    logic sel_config;
    logic sel_edge;
    logic sel_setclr;
    logic sel_any;
    logic do_capture;
    logic do_update;
    logic do_shift;

    // Instruction priority: data > config > edge > setclr.
    assign sel_data   = gpio_data_ir;
    assign sel_config = gpio_config_ir & ~gpio_data_ir;
    assign sel_edge   = gpio_edge_ir & ~gpio_config_ir & ~gpio_data_ir;
    assign sel_setclr = gpio_setclr_ir & ~gpio_edge_ir & ~gpio_config_ir & ~gpio_data_ir;
    assign sel_any    = sel_data | sel_config | sel_edge | sel_setclr;

    // TAP-state priority: capture > update > shift. Nothing happens when no IR is selected.
    assign do_capture = sel_any & capture_dr;
    assign do_update  = sel_any & update_dr & ~capture_dr;
    assign do_shift   = sel_any & shift_dr & ~update_dr & ~capture_dr;

    assign in_sync      = sync_q[SYNC_STAGES-1];
    assign new_edges    = (rise_ena & in_sync & ~in_prev) | (fall_ena & ~in_sync & in_prev);
    assign edge_pending = |edge_status;
    assign gpios_tdo    = sr[0];
    assign sr_down      = sr >> 1;

    // Shift only the active DR window. Bits above the window keep their value.
    always_comb begin
        int dr_len;
        dr_len     = NR_GPIOS;
        sr_shifted = sr;
        if (sel_config) begin
            dr_len = 3 * NR_GPIOS;
        end else if (sel_setclr) begin
            dr_len = 2 * NR_GPIOS;
        end
        for (int i = 0; i < SR_W; i++) begin
            if (i < dr_len - 1) begin
                sr_shifted[i] = sr_down[i];
            end else if (i == dr_len - 1) begin
                sr_shifted[i] = tdi;
            end
        end
    end

    // Select the capture value for the active view. Upper bits are zero-filled.
    always_comb begin
        sr_capture = '0;
        if (sel_data) begin
            sr_capture = SR_W'(in_sync);
        end else if (sel_config) begin
            sr_capture = {fall_ena, rise_ena, gpio_outputs_ena};
        end else if (sel_edge) begin
            sr_capture = SR_W'(edge_status);
        end else if (sel_setclr) begin
            sr_capture = SR_W'(gpio_outputs);
        end
    end

    // Synchronise the raw pins, then keep a one-cycle history for edge detection.
    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            in_prev <= '0;
        end else begin
            sync_q[0] <= gpio_inputs;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            in_prev <= in_sync;
        end
    end

    // Scan register: capture, shift, or hold.
    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            sr <= '0;
        end else if (do_capture) begin
            sr <= sr_capture;
        end else if (do_shift) begin
            sr <= sr_shifted;
        end
    end

    // Output values, output enables and edge enables are written by update.
    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            gpio_outputs     <= '0;
            gpio_outputs_ena <= '0;
            rise_ena         <= '0;
            fall_ena         <= '0;
        end else if (do_update) begin
            if (sel_data) begin
                gpio_outputs <= sr[NR_GPIOS-1:0];
            end else if (sel_config) begin
                gpio_outputs_ena <= sr[NR_GPIOS-1:0];
                rise_ena         <= sr[2*NR_GPIOS-1:NR_GPIOS];
                fall_ena         <= sr[3*NR_GPIOS-1:2*NR_GPIOS];
            end else if (sel_setclr) begin
                // When set and clear are both 1, set wins.
                gpio_outputs <= (gpio_outputs & ~sr[2*NR_GPIOS-1:NR_GPIOS]) | sr[NR_GPIOS-1:0];
            end
        end
    end

    // Sticky edge status. A new edge that arrives with a clearing update survives.
    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            edge_status <= '0;
        end else if (do_update && sel_edge) begin
            edge_status <= (edge_status & ~sr[NR_GPIOS-1:0]) | new_edges;
        end else begin
            edge_status <= edge_status | new_edges;
        end
    end

endmodule
